// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and default sizing for the binary GCD engine
package gcd_pkg;

    // Default operand/result width in bits.
    localparam int GCD_WIDTH_DEFAULT = 16;

    // Default number of cycles done and gcd are held in FINISH.
    localparam int GCD_DONE_HOLD_DEFAULT = 2;

    // Default width of the optional iteration counter.
    localparam int GCD_CNT_W_DEFAULT = 8;

    // Controller states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one combinational iteration of the binary (Stein) GCD algorithm
module gcd_step #(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] ra_nxt,
    output logic [WIDTH-1:0] rb_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic             term,
    output logic [WIDTH-1:0] result
);

    localparam logic [KW-1:0] K_ONE = KW'(1);

    // Priority-ordered single operation: terminate, halve both, halve one, or subtract.
    always_comb begin
        ra_nxt = ra;
        rb_nxt = rb;
        k_nxt  = k;
        term   = 1'b0;
        // The common power of two is restored here; it cannot overflow because
        // the true gcd never exceeds the larger original operand.
        result = (ra | rb) << k;
        if ((ra == '0) || (rb == '0)) begin
            term = 1'b1;
        end else if (!ra[0] && !rb[0]) begin
            ra_nxt = ra >> 1;
            rb_nxt = rb >> 1;
            k_nxt  = k + K_ONE;
        end else if (!ra[0]) begin
            ra_nxt = ra >> 1;
        end else if (!rb[0]) begin
            rb_nxt = rb >> 1;
        end else if (ra >= rb) begin
            ra_nxt = ra - rb;
        end else begin
            rb_nxt = rb - ra;
        end
    end

endmodule

// File: rtl/binary_gcd_engine.sv
// rtl/binary_gcd_engine.sv - iterative binary GCD controller; GCD_ITER_CNT_EN adds iter_cnt output
module binary_gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH     = GCD_WIDTH_DEFAULT,
    parameter int DONE_HOLD = GCD_DONE_HOLD_DEFAULT,
    parameter int CNT_W     = GCD_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    // Reject configurations that cannot work at elaboration time.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("binary_gcd_engine: WIDTH must be at least 2");
        end
        if (DONE_HOLD < 1) begin : g_bad_hold
            $error("binary_gcd_engine: DONE_HOLD must be at least 1");
        end
        if ((1 << CNT_W) <= 3 * WIDTH) begin : g_bad_cnt
            $error("binary_gcd_engine: CNT_W too narrow for 3*WIDTH iterations");
        end
    endgenerate

    gcd_state_t       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [KW-1:0]    k;
    logic [HW-1:0]    hold_cnt;

    logic [WIDTH-1:0] ra_nxt;
    logic [WIDTH-1:0] rb_nxt;
    logic [KW-1:0]    k_nxt;
    logic             term;
    logic [WIDTH-1:0] result;

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .ra     (ra),
        .rb     (rb),
        .k      (k),
        .ra_nxt (ra_nxt),
        .rb_nxt (rb_nxt),
        .k_nxt  (k_nxt),
        .term   (term),
        .result (result)
    );

    // Controller: operand tracking in IDLE, one step per CALC cycle, timed result hold in FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            gcd      <= '0;
            ra       <= '0;
            rb       <= '0;
            k        <= '0;
            hold_cnt <= '0;
`ifdef GCD_ITER_CNT_EN
            iter_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // Operands follow the inputs so the accepting edge captures them.
                    ra       <= a;
                    rb       <= b;
                    k        <= '0;
                    done     <= 1'b0;
                    gcd      <= '0;
                    hold_cnt <= '0;
                    if (start) begin
                        state <= ST_CALC;
                        busy  <= 1'b1;
`ifdef GCD_ITER_CNT_EN
                        iter_cnt <= '0;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CALC: begin
`ifdef GCD_ITER_CNT_EN
                    iter_cnt <= iter_cnt + CNT_W'(1);
`endif
                    if (term) begin
                        gcd      <= result;
                        done     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_FINISH;
                    end else begin
                        ra <= ra_nxt;
                        rb <= rb_nxt;
                        k  <= k_nxt;
                    end
                end
                ST_FINISH: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        gcd      <= '0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    gcd      <= '0;
                    ra       <= '0;
                    rb       <= '0;
                    k        <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_gcd_engine.sv
// tb/tb_binary_gcd_engine.sv - self-checking bench for binary_gcd_engine
module tb_binary_gcd_engine;

    localparam int WIDTH     = 16;
    localparam int DONE_HOLD = 2;
    localparam int CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd;
`ifdef GCD_ITER_CNT_EN
    logic [CNT_W-1:0] iter_cnt;
`endif

    int errors = 0;
    int checks = 0;

    binary_gcd_engine #(
        .WIDTH     (WIDTH),
        .DONE_HOLD (DONE_HOLD),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gcd   (gcd)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference gcd by Euclid's remainder method (independent of the shift/subtract rules).
    function automatic int m_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of iteration cycles the shift/subtract rules need, counting the terminating one.
    function automatic int m_cycles(input int x, input int y);
        int n = 0;
        while (n < 1000) begin
            n++;
            if (x == 0 || y == 0) return n;
            if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
            else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0) y = y / 2;
            else if (x >= y) x = x - y;
            else y = y - x;
        end
        return n;
    endfunction

    // Cycle-level expectation: idle / computing for N cycles / presenting for DONE_HOLD cycles.
    int m_phase = 0;
    int m_left  = 0;
    int m_hold  = 0;
    int m_res   = 0;
    int m_iter  = 0;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_out  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_busy = 1'b0; m_done = 1'b0; m_out = 0; m_left = 0; m_hold = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_busy  = 1'b1;
                    m_left  = m_cycles(int'(a), int'(b));
                    m_res   = m_gcd(int'(a), int'(b));
                    m_iter  = m_left;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_done  = 1'b1;
                        m_out   = m_res;
                        m_hold  = DONE_HOLD;
                    end
                end
                default: begin
                    m_hold--;
                    if (m_hold == 0) begin
                        m_phase = 0;
                        m_busy  = 1'b0;
                        m_done  = 1'b0;
                        m_out   = 0;
                    end
                end
            endcase
        end
    end

    // Compare DUT outputs against the expectation every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_gcd", 32'(gcd), 32'(m_out));
`ifdef GCD_ITER_CNT_EN
            if (m_done) check("cyc_iter_cnt", 32'(iter_cnt), 32'(m_iter));
`endif
        end
    end

    // One request with hand-computed result and iteration count; optionally a stray start mid-run.
    task automatic run_op(input int va, input int vb, input int exp_gcd, input int exp_lat,
                          input bit pulse_mid);
        int lat;
        int h;
        @(posedge clk); #1;
        a = WIDTH'(va); b = WIDTH'(vb); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        lat = 0;
        while (!done && lat < 200) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (pulse_mid && lat == 2) begin
                a = WIDTH'(10); b = WIDTH'(4); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 1);
        check("result", 32'(gcd), 32'(exp_gcd));
        check("calc_cycles", 32'(lat), 32'(exp_lat));
        check("calc_bound", 32'(lat <= 3 * WIDTH), 1);
        h = 0;
        while (done && h < 50) begin
            check("gcd_stable", 32'(gcd), 32'(exp_gcd));
            @(posedge clk); #1;
            h++;
        end
        check("done_hold", 32'(h), DONE_HOLD);
        check("gcd_after", 32'(gcd), 0);
        check("busy_after", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_gcd", 32'(gcd), 0);
        rst_n = 1'b1;

        check("model_gcd_48_18", 32'(m_gcd(48, 18)), 6);
        check("model_gcd_0_0", 32'(m_gcd(0, 0)), 0);
        check("model_cycles_0_35", 32'(m_cycles(0, 35)), 1);
        check("model_cycles_32768_12288", 32'(m_cycles(32768, 12288)), 19);

        run_op(48, 18, 6, 8, 1'b0);
        run_op(0, 35, 35, 1, 1'b0);
        run_op(0, 0, 0, 1, 1'b0);
        run_op(65535, 65535, 65535, 2, 1'b0);
        run_op(32768, 12288, 4096, 19, 1'b0);
        run_op(35, 0, 35, 1, 1'b0);

        // Stray start mid-computation must not queue a second result.
        run_op(48, 18, 6, 8, 1'b1);
        dones = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("no_second_done", 32'(dones), 0);

        // Asynchronous reset between edges aborts the request immediately.
        @(posedge clk); #1;
        a = WIDTH'(32768); b = WIDTH'(12288); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_gcd", 32'(gcd), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 0);

        run_op(21, 14, 7, 5, 1'b0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
